pid_sample_sequencer: RTL and testbench
=======================================

Name: pid_sample_sequencer

Overview:
Front-end initiator for the PID core. It accepts raw sensor/ADC samples over a valid/ready handshake and averages a power-of-two block of them. It then presents the average on the PID core's data input and issues a single-cycle pid_start strobe, at a fixed control-loop period. It sits between the ADC interface and the pid block and owns loop timing.

Parameters:
DATA_W, 16, sample and data_in width
AVG_LOG2, 2, log2 of samples averaged per frame (4 samples)
PERIOD, 20, clock cycles between successive ACCUM entries (control-loop period), must be > 2^AVG_LOG2 + DATA_SETUP + 1
DATA_SETUP, 1, cycles data_in is stable before pid_start asserts (>=1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous assert, active-low
en  in  1  run enable
adc_valid  in  1  sample valid
adc_data  in  DATA_W  raw sample, unsigned
adc_ready  out  1  block accepts sample this cycle
overrun_clr  in  1  clears overrun flag
data_in  out  DATA_W  averaged sample to pid data_in, registered
pid_start  out  1  one-cycle start strobe to pid
busy  out  1  high in any state except IDLE
overrun  out  1  sticky: frame exceeded PERIOD

Behaviour:
- One clock domain, clk. Reset is asynchronous and active-low (rst_n). All flops clear immediately on rst_n=0.
- Reset values: data_in=0, pid_start=0, adc_ready=0, busy=0, overrun=0, state=IDLE, accumulator=0, sample count=0, period counter=0.
- Accumulator width is DATA_W+AVG_LOG2 with zero-extended samples; it never overflows. Average = accumulator >> AVG_LOG2, truncated, with no rounding.
- State machine:
  - IDLE: adc_ready=0. If en=1, go to ACCUM next cycle, clear accumulator/count and zero the period counter.
  - ACCUM: adc_ready=1. Each cycle with adc_valid&adc_ready, add the sample and increment count.
    - On acceptance of sample 2^AVG_LOG2, data_in <= average at that same edge and go to SETUP.
    - If en=0 in ACCUM, abort to IDLE, discard the partial sum, and leave data_in unchanged.
  - SETUP: adc_ready=0. Hold DATA_SETUP cycles, counting from the cycle data_in first shows the new value, then go to START.
  - START: pid_start=1 for exactly one cycle, then go to WAIT.
  - WAIT: adc_ready=0. When the period counter reaches PERIOD-1: if en=1, go to ACCUM (counter to 0, accumulator cleared); otherwise go to IDLE. If en=0 at any point in WAIT, go to IDLE next cycle.
- Period counter: increments every cycle outside IDLE and restarts at 0 on each ACCUM entry. Consecutive pid_start rising edges are therefore exactly PERIOD cycles apart while samples arrive in time.
- Overrun: if the counter reaches PERIOD-1 while in ACCUM or SETUP:
  - overrun <= 1 and the counter saturates.
  - The frame still completes.
  - After START, go directly to ACCUM (skip WAIT).
  - overrun_clr=1 clears the flag. If a set and a clear occur in the same cycle, set wins.
- en=0 during SETUP or START does not suppress the pending pid_start. The frame completes, then the block goes to IDLE.
- data_in changes only on frame completion and is stable from one cycle before pid_start until the next frame completes, at least through pid_start.
- A sample presented while adc_ready=0 is not consumed. The handshake is standard: transfer only when valid&ready.
- Latency: last sample accepted at edge N gives data_in updated at edge N and pid_start high in the cycle after edge N+DATA_SETUP.
- rst_n asserted mid-frame returns the block to reset state immediately. No pid_start is emitted after release until en=1 and a fresh full block of samples has been accepted.

Test Plan:
1. Defaults, en=1, adc_valid=1 with samples 54320, 54322, 54321, 54321 -> data_in=54321 one cycle after the 4th sample edge, pid_start high for exactly 1 cycle on the following cycle, busy=1.
2. Four samples of 65535 -> data_in=65535 with no wrap. Samples 1, 2, 2, 2 -> data_in=1 (7>>2, truncation).
3. Continuous adc_valid=1 for 100 cycles -> pid_start rising edges exactly 20 cycles apart, adc_ready=0 throughout SETUP/START/WAIT, exactly 4 samples consumed per frame, overrun stays 0.
4. adc_valid pulsed once every 8 cycles -> 4th sample lands after cycle 19, overrun=1, pid_start still issued with the correct average, next ACCUM starts immediately. Pulse overrun_clr -> overrun=0.
5. en dropped after 2 accepted samples -> IDLE next cycle, no pid_start, data_in keeps its previous value. en dropped during SETUP -> pid_start still issued once, then IDLE.
6. rst_n=0 mid-ACCUM, asynchronous between edges -> all outputs 0 immediately. After release with en=1, the first pid_start occurs only after 4 new samples.

Source files
------------

// File: rtl/pid_sample_sequencer.sv
// Front-end sequencer for the PID core: averages 2^AVG_LOG2 ADC samples per frame,
// presents the average on data_in and fires pid_start once per control-loop period.
module pid_sample_sequencer #(
    parameter int DATA_W     = 16,
    parameter int AVG_LOG2   = 2,
    parameter int PERIOD     = 20,
    parameter int DATA_SETUP = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              adc_valid,
    input  logic [DATA_W-1:0] adc_data,
    output logic              adc_ready,
    input  logic              overrun_clr,
    output logic [DATA_W-1:0] data_in,
    output logic              pid_start,
    output logic              busy,
    output logic              overrun
);

    localparam int ACC_W = DATA_W + AVG_LOG2;
    localparam int CNT_W = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    localparam int SET_W = (DATA_SETUP > 1) ? $clog2(DATA_SETUP) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(DATA_SETUP - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ACCUM, S_SETUP, S_START, S_WAIT
    } state_t;

    state_t            state_q;
    logic [ACC_W-1:0]  acc_q;
    logic [AVG_LOG2-1:0] n_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [SET_W-1:0]  set_q;
    logic [DATA_W-1:0] data_q;
    logic              ready_q;
    logic              start_q;
    logic              busy_q;
    logic              ovr_q;

    logic [ACC_W-1:0]  acc_d;
    logic              period_end;
    logic              accept;

    assign acc_d      = acc_q + ACC_W'(adc_data);
    assign period_end = (cnt_q == CNT_LAST);
    assign accept     = adc_valid & ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            n_q     <= '0;
            cnt_q   <= '0;
            set_q   <= '0;
            data_q  <= '0;
            ready_q <= 1'b0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            start_q <= 1'b0;
            // Period counter saturates at PERIOD-1; state entries below override it.
            if (state_q != S_IDLE && !period_end)
                cnt_q <= cnt_q + 1'b1;
            if ((state_q == S_ACCUM || state_q == S_SETUP) && period_end)
                ovr_q <= 1'b1;
            else if (overrun_clr)
                ovr_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (en) begin
                        state_q <= S_ACCUM;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b1;
                        acc_q   <= '0;
                        n_q     <= '0;
                        cnt_q   <= '0;
                    end
                end
                S_ACCUM: begin
                    if (!en) begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else if (accept) begin
                        acc_q <= acc_d;
                        n_q   <= n_q + 1'b1;
                        if (&n_q) begin
                            data_q  <= acc_d[ACC_W-1:AVG_LOG2];
                            state_q <= S_SETUP;
                            ready_q <= 1'b0;
                            set_q   <= '0;
                        end
                    end
                end
                S_SETUP: begin
                    if (set_q == SET_LAST) begin
                        state_q <= S_START;
                        start_q <= 1'b1;
                    end else begin
                        set_q <= set_q + 1'b1;
                    end
                end
                S_START: begin
                    // A late frame has already used up its period: restart collection at once.
                    if (!en) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else if (period_end) begin
                        state_q <= S_ACCUM;
                        ready_q <= 1'b1;
                        acc_q   <= '0;
                        n_q     <= '0;
                        cnt_q   <= '0;
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!en) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else if (period_end) begin
                        state_q <= S_ACCUM;
                        ready_q <= 1'b1;
                        acc_q   <= '0;
                        n_q     <= '0;
                        cnt_q   <= '0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign adc_ready = ready_q;
    assign data_in   = data_q;
    assign pid_start = start_q;
    assign busy      = busy_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_pid_sample_sequencer.sv
// Randomized bench for pid_sample_sequencer against a timeline model of frames:
// frame start time, accepted samples, last-sample time and derived START/period times.
module tb_pid_sample_sequencer;
    localparam int DW = 16, AL = 2, P = 20, DS = 1, NS = 1 << AL;

    logic clk = 1'b0, rst_n = 1'b1, en = 1'b0, adc_valid = 1'b0, overrun_clr = 1'b0;
    logic [DW-1:0] adc_data = '0;
    logic adc_ready, pid_start, busy, overrun;
    logic [DW-1:0] data_in;

    pid_sample_sequencer #(.DATA_W(DW), .AVG_LOG2(AL), .PERIOD(P), .DATA_SETUP(DS)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .adc_valid(adc_valid), .adc_data(adc_data),
        .adc_ready(adc_ready), .overrun_clr(overrun_clr), .data_in(data_in),
        .pid_start(pid_start), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int cyc;
    // Model: frame started at cycle m_fs, m_n samples summed, last sample accepted at end of cycle m_a.
    bit m_active, m_ovr, m_acc;
    int m_fs, m_sum, m_n, m_a;
    logic [DW-1:0] m_data;
    logic e_rdy, e_pid, e_busy, e_ovr;
    logic [DW-1:0] e_data;

    task model_clear();
        m_active = 0; m_ovr = 0; m_acc = 0; m_fs = 0; m_sum = 0; m_n = 0; m_a = -1;
        m_data = '0; cyc = 0;
        e_rdy = 0; e_pid = 0; e_busy = 0; e_ovr = 0; e_data = '0;
    endtask

    task new_frame(input int c);
        m_fs = c; m_n = 0; m_sum = 0; m_a = -1;
    endtask

    task do_reset();
        rst_n = 1'b0; en = 0; adc_valid = 0; overrun_clr = 0; adc_data = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_clear();
    endtask

    // Advance one clock: apply frame rules to the inputs of the ending cycle, then derive expectations.
    task tick();
        int c0, s;
        bit set;
        @(posedge clk);
        m_acc = 0; set = 0; c0 = cyc;
        if (!m_active) begin
            if (en) begin m_active = 1; new_frame(c0 + 1); end
        end else if (m_a < 0) begin
            if (c0 - m_fs >= P - 1) set = 1;
            if (!en) m_active = 0;
            else if (adc_valid) begin
                m_acc = 1; m_sum += int'(adc_data); m_n++;
                if (m_n == NS) begin m_a = c0; m_data = DW'(m_sum >> AL); end
            end
        end else begin
            s = m_a + 1 + DS;
            if (c0 < s) begin
                if (c0 - m_fs >= P - 1) set = 1;
            end else if (c0 == s) begin
                if (!en) m_active = 0;
                else if (s - m_fs >= P - 1) new_frame(c0 + 1);
            end else begin
                if (!en) m_active = 0;
                else if (c0 - m_fs == P - 1) new_frame(c0 + 1);
            end
        end
        if (set) m_ovr = 1;
        else if (overrun_clr) m_ovr = 0;
        cyc++;
        @(negedge clk);
        e_rdy  = m_active && (m_a < 0);
        e_busy = m_active;
        e_pid  = m_active && (m_a >= 0) && (cyc == m_a + 1 + DS);
        e_data = m_data;
        e_ovr  = m_ovr;
    endtask

    task test_reset();
        do_reset();
        checks++;
        if ({adc_ready, pid_start, busy, overrun, data_in} !== '0) begin
            errors++;
            $display("FAIL reset: got rdy=%b pid=%b busy=%b ovr=%b data=%0d, want all 0",
                     adc_ready, pid_start, busy, overrun, data_in);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({adc_ready, pid_start, busy, overrun, data_in} !== {e_rdy, e_pid, e_busy, e_ovr, e_data}) begin
                errors++;
                $display("FAIL idle cyc %0d: got rdy=%b pid=%b busy=%b ovr=%b data=%0d, want %b %b %b %b %0d",
                         cyc, adc_ready, pid_start, busy, overrun, data_in, e_rdy, e_pid, e_busy, e_ovr, e_data);
            end
        end
    endtask

    task test_basic();
        logic [DW-1:0] smp [4];
        int idx, npid;
        smp = '{16'd54320, 16'd54322, 16'd54321, 16'd54321};
        do_reset();
        en = 1; adc_valid = 1; adc_data = smp[0]; idx = 0; npid = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if ({adc_ready, pid_start, busy, overrun, data_in} !== {e_rdy, e_pid, e_busy, e_ovr, e_data}) begin
                errors++;
                $display("FAIL basic cyc %0d: got rdy=%b pid=%b busy=%b ovr=%b data=%0d, want %b %b %b %b %0d",
                         cyc, adc_ready, pid_start, busy, overrun, data_in, e_rdy, e_pid, e_busy, e_ovr, e_data);
            end
            if (pid_start === 1'b1) begin
                npid++; checks++;
                if (data_in !== 16'd54321 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL basic_avg: got data=%0d busy=%b, want 54321 1", data_in, busy);
                end
            end
            if (m_acc) begin idx++; adc_data = (idx < 4) ? smp[idx] : DW'($urandom); end
        end
        checks++;
        if (npid != 1) begin errors++; $display("FAIL basic_pid_count: got %0d, want 1", npid); end
    endtask

    task test_boundary();
        logic [DW-1:0] smp [8];
        logic [DW-1:0] want [2];
        int idx, npid;
        smp  = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd1, 16'd2, 16'd2, 16'd2};
        want = '{16'hFFFF, 16'd1};
        do_reset();
        en = 1; adc_valid = 1; adc_data = smp[0]; idx = 0; npid = 0;
        for (int i = 0; i < 32; i++) begin
            tick();
            checks++;
            if ({adc_ready, pid_start, busy, overrun, data_in} !== {e_rdy, e_pid, e_busy, e_ovr, e_data}) begin
                errors++;
                $display("FAIL boundary cyc %0d: got rdy=%b pid=%b busy=%b ovr=%b data=%0d, want %b %b %b %b %0d",
                         cyc, adc_ready, pid_start, busy, overrun, data_in, e_rdy, e_pid, e_busy, e_ovr, e_data);
            end
            if (pid_start === 1'b1 && npid < 2) begin
                checks++;
                if (data_in !== want[npid]) begin
                    errors++;
                    $display("FAIL boundary_avg%0d: got %0d, want %0d", npid, data_in, want[npid]);
                end
                npid++;
            end
            if (m_acc) begin idx++; adc_data = (idx < 8) ? smp[idx] : DW'($urandom); end
        end
        checks++;
        if (npid != 2) begin errors++; $display("FAIL boundary_pid_count: got %0d, want 2", npid); end
    endtask

    task test_continuous();
        int last, nacc, npid;
        do_reset();
        en = 1; adc_valid = 1; adc_data = DW'($urandom); last = -1; nacc = 0; npid = 0;
        for (int i = 0; i < 110; i++) begin
            tick();
            checks++;
            if ({adc_ready, pid_start, busy, overrun, data_in} !== {e_rdy, e_pid, e_busy, e_ovr, e_data}) begin
                errors++;
                $display("FAIL continuous cyc %0d: got rdy=%b pid=%b busy=%b ovr=%b data=%0d, want %b %b %b %b %0d",
                         cyc, adc_ready, pid_start, busy, overrun, data_in, e_rdy, e_pid, e_busy, e_ovr, e_data);
            end
            if (m_acc) begin nacc++; adc_data = DW'($urandom); end
            if (pid_start === 1'b1) begin
                npid++; checks++;
                if ((last >= 0 && cyc - last != P) || nacc != NS) begin
                    errors++;
                    $display("FAIL continuous_period: got gap=%0d samples=%0d, want gap=%0d samples=%0d",
                             cyc - last, nacc, P, NS);
                end
                last = cyc; nacc = 0;
            end
        end
        checks++;
        if (overrun !== 1'b0 || npid < 5) begin
            errors++;
            $display("FAIL continuous_summary: got ovr=%b pids=%0d, want ovr=0 pids>=5", overrun, npid);
        end
    endtask

    task test_overrun();
        do_reset();
        en = 1; adc_valid = 1'(cyc % 8 == 0); adc_data = DW'($urandom);
        for (int i = 0; i < 70; i++) begin
            tick();
            checks++;
            if ({adc_ready, pid_start, busy, overrun, data_in} !== {e_rdy, e_pid, e_busy, e_ovr, e_data}) begin
                errors++;
                $display("FAIL overrun cyc %0d: got rdy=%b pid=%b busy=%b ovr=%b data=%0d, want %b %b %b %b %0d",
                         cyc, adc_ready, pid_start, busy, overrun, data_in, e_rdy, e_pid, e_busy, e_ovr, e_data);
            end
            adc_valid = 1'(cyc % 8 == 0);
            if (m_acc) adc_data = DW'($urandom);
        end
        checks++;
        if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b, want 1", overrun); end
        en = 0; adc_valid = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 6) overrun_clr = 1;
            if (i == 7) overrun_clr = 0;
            tick();
            checks++;
            if ({adc_ready, pid_start, busy, overrun, data_in} !== {e_rdy, e_pid, e_busy, e_ovr, e_data}) begin
                errors++;
                $display("FAIL overrun_clr cyc %0d: got rdy=%b pid=%b busy=%b ovr=%b data=%0d, want %b %b %b %b %0d",
                         cyc, adc_ready, pid_start, busy, overrun, data_in, e_rdy, e_pid, e_busy, e_ovr, e_data);
            end
        end
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_cleared: got %b, want 0", overrun); end
    endtask

    task test_abort();
        int npid, i;
        bit hit;
        logic [DW-1:0] keep;
        do_reset();
        en = 1; adc_valid = 1; adc_data = DW'($urandom); npid = 0; hit = 0;
        for (i = 0; i < 60 && !hit; i++) begin
            tick();
            checks++;
            if ({adc_ready, pid_start, busy, overrun, data_in} !== {e_rdy, e_pid, e_busy, e_ovr, e_data}) begin
                errors++;
                $display("FAIL abort cyc %0d: got rdy=%b pid=%b busy=%b ovr=%b data=%0d, want %b %b %b %b %0d",
                         cyc, adc_ready, pid_start, busy, overrun, data_in, e_rdy, e_pid, e_busy, e_ovr, e_data);
            end
            if (pid_start === 1'b1) npid++;
            if (m_acc) adc_data = DW'($urandom);
            if (npid >= 1 && m_acc && m_n == 2) begin en = 0; hit = 1; end
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL abort_timeout: got no second partial frame, want one"); end
        keep = m_data; npid = 0;
        for (i = 0; i < 6; i++) begin
            tick();
            checks++;
            if ({adc_ready, pid_start, busy, overrun, data_in} !== {e_rdy, e_pid, e_busy, e_ovr, e_data}) begin
                errors++;
                $display("FAIL abort_idle cyc %0d: got rdy=%b pid=%b busy=%b ovr=%b data=%0d, want %b %b %b %b %0d",
                         cyc, adc_ready, pid_start, busy, overrun, data_in, e_rdy, e_pid, e_busy, e_ovr, e_data);
            end
            if (pid_start === 1'b1) npid++;
        end
        checks++;
        if (npid != 0 || data_in !== keep || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_hold: got pids=%0d data=%0d busy=%b, want 0 %0d 0", npid, data_in, busy, keep);
        end
        // Second part: drop en while the averaged value is being set up.
        en = 1; hit = 0;
        for (i = 0; i < 40 && !hit; i++) begin
            tick();
            checks++;
            if ({adc_ready, pid_start, busy, overrun, data_in} !== {e_rdy, e_pid, e_busy, e_ovr, e_data}) begin
                errors++;
                $display("FAIL setup_drop cyc %0d: got rdy=%b pid=%b busy=%b ovr=%b data=%0d, want %b %b %b %b %0d",
                         cyc, adc_ready, pid_start, busy, overrun, data_in, e_rdy, e_pid, e_busy, e_ovr, e_data);
            end
            if (m_acc) adc_data = DW'($urandom);
            if (m_a >= 0 && cyc == m_a + 1) begin en = 0; hit = 1; end
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL setup_drop_timeout: got no completed frame, want one"); end
        npid = 0;
        for (i = 0; i < 6; i++) begin
            tick();
            checks++;
            if ({adc_ready, pid_start, busy, overrun, data_in} !== {e_rdy, e_pid, e_busy, e_ovr, e_data}) begin
                errors++;
                $display("FAIL setup_drop_tail cyc %0d: got rdy=%b pid=%b busy=%b ovr=%b data=%0d, want %b %b %b %b %0d",
                         cyc, adc_ready, pid_start, busy, overrun, data_in, e_rdy, e_pid, e_busy, e_ovr, e_data);
            end
            if (pid_start === 1'b1) npid++;
        end
        checks++;
        if (npid != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL setup_drop_pid: got pids=%0d busy=%b, want 1 0", npid, busy);
        end
    endtask

    task test_async_reset();
        int nacc;
        bit seen;
        do_reset();
        en = 1; adc_valid = 1; adc_data = DW'($urandom);
        for (int i = 0; i < 10 && m_n < 2; i++) begin
            tick();
            if (m_acc) adc_data = DW'($urandom);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({adc_ready, pid_start, busy, overrun, data_in} !== '0 || m_n != 2) begin
            errors++;
            $display("FAIL async_reset: got rdy=%b pid=%b busy=%b ovr=%b data=%0d samples=%0d, want all 0 after 2 samples",
                     adc_ready, pid_start, busy, overrun, data_in, m_n);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        nacc = 0; seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            tick();
            checks++;
            if ({adc_ready, pid_start, busy, overrun, data_in} !== {e_rdy, e_pid, e_busy, e_ovr, e_data}) begin
                errors++;
                $display("FAIL after_reset cyc %0d: got rdy=%b pid=%b busy=%b ovr=%b data=%0d, want %b %b %b %b %0d",
                         cyc, adc_ready, pid_start, busy, overrun, data_in, e_rdy, e_pid, e_busy, e_ovr, e_data);
            end
            if (m_acc) begin nacc++; adc_data = DW'($urandom); end
            if (pid_start === 1'b1) seen = 1;
        end
        checks++;
        if (!seen || nacc != NS) begin
            errors++;
            $display("FAIL after_reset_first_pid: got seen=%b samples=%0d, want 1 %0d", seen, nacc, NS);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundary();
        test_continuous();
        test_overrun();
        test_abort();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
